// File: rtl/vib_alarm_reporter_if.sv
// Event port from the alarm reporter to the host frame builder.
// One event per valid/ready handshake; payload is held while valid is high.
interface vib_alarm_reporter_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_ch;
  logic       evt_level;
  logic [7:0] evt_seq;

  modport master (
    output evt_valid, evt_ch, evt_level, evt_seq,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_ch, evt_level, evt_seq,
    output evt_ready
  );
endinterface

// File: rtl/vib_alarm_reporter.sv
// Round-robin reporter: turns alarm edges on four channels into events on one
// valid/ready port, with an enforced idle gap and a saturating lost-event count.
module vib_alarm_reporter #(
  parameter int         GAP_CYC      = 4,
  parameter logic [1:0] RR_RESET_PTR = 2'd3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3:0]           alarm,
  input  logic [3:0]           cfg_mask,
  vib_alarm_reporter_if.master evt,
  output logic                 alarm_any,
  output logic [7:0]           overrun_cnt
);

  localparam int         GW       = $clog2(GAP_CYC + 2);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = last;
    found   = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  function automatic logic [2:0] cnt4(input logic [3:0] v);
    cnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [2:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {6'b0, b};
    sat_add8 = s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t        state, state_nxt;
  logic [3:0]    alarm_r, alarm_d;
  logic [3:0]    edge_hit, pending, pend_nxt, lvl, grant_mask, ovr_hits;
  logic [1:0]    rr_ptr, grant_ch;
  logic          grant, hs;
  logic [GW-1:0] gap_cnt;
  logic          valid_q, level_q;
  logic [1:0]    ch_q;
  logic [7:0]    seq_q;

  assign evt.evt_valid = valid_q;
  assign evt.evt_ch    = ch_q;
  assign evt.evt_level = level_q;
  assign evt.evt_seq   = seq_q;

  // edge detect on the two-deep alarm history, masked channels produce no edges
  assign edge_hit   = (alarm_r ^ alarm_d) & ~cfg_mask;
  assign grant_mask = grant ? (4'b0001 << grant_ch) : 4'b0000;
  // a same-cycle grant consumes the old level, so that edge is not an overrun
  assign ovr_hits   = edge_hit & pending & ~grant_mask;
  assign pend_nxt   = ((pending & ~grant_mask) | edge_hit) & ~cfg_mask;

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    hs        = 1'b0;
    grant_ch  = rr_pick(pending, rr_ptr);
    unique case (state)
      IDLE: if (|pending) begin
        grant     = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (evt.evt_ready) begin
        hs        = 1'b1;
        state_nxt = (GAP_CYC > 0) ? GAP : IDLE;
      end
      GAP: if (gap_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_r     <= '0;
      alarm_d     <= '0;
      pending     <= '0;
      rr_ptr      <= RR_RESET_PTR;
      gap_cnt     <= '0;
      valid_q     <= 1'b0;
      ch_q        <= '0;
      level_q     <= 1'b0;
      seq_q       <= '0;
      alarm_any   <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      alarm_r     <= alarm;
      alarm_d     <= alarm_r;
      pending     <= pend_nxt;
      alarm_any   <= |(alarm_r & ~cfg_mask);
      overrun_cnt <= sat_add8(overrun_cnt, cnt4(ovr_hits));
      if (grant) begin
        rr_ptr  <= grant_ch;
        ch_q    <= grant_ch;
        level_q <= lvl[grant_ch];
        valid_q <= 1'b1;
      end else if (hs) begin
        valid_q <= 1'b0;
        seq_q   <= seq_q + 8'd1;
      end
      if (hs)
        gap_cnt <= GAP_LOAD;
      else if (state == GAP && gap_cnt != '0)
        gap_cnt <= gap_cnt - GW'(1);
    end
  end

  // newest level wins while an event is still queued
  always_ff @(posedge clk) begin
    lvl <= (lvl & ~edge_hit) | (alarm_r & edge_hit);
  end

endmodule
